// File: rtl/four_bit_serial_loader_if.sv
// Bus bundle for the serial nibble loader: serial input side plus the
// word handshake towards the downstream 4-bit register.
interface four_bit_serial_loader_if;
    logic       start;
    logic       ser_in;
    logic       ser_valid;
    logic       word_ready;
    logic [3:0] word_out;
    logic       word_valid;
    logic       busy;
    logic       overrun;

    // Producer of serial bits and consumer of completed words
    modport master (
        output start, ser_in, ser_valid, word_ready,
        input  word_out, word_valid, busy, overrun
    );

    // The loader itself
    modport slave (
        input  start, ser_in, ser_valid, word_ready,
        output word_out, word_valid, busy, overrun
    );
endinterface

// File: rtl/four_bit_serial_loader.sv
// Serial-to-parallel front end: gathers four LSB-first bits after a start
// request and offers the finished nibble on a valid/ready handshake.
// Partial words never reach word_out; every output comes straight from a flop.
module four_bit_serial_loader (
    input  logic                     clk,
    input  logic                     rst,
    four_bit_serial_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] buf_q, buf_d;
    logic [3:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;

    // Next-state logic: capture bits, publish the word, and run the handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        word_d    = word_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    cnt_d     = 2'd0;
                    overrun_d = 1'b0;
                    busy_d    = 1'b1;
                    valid_d   = 1'b0;
                end
            end

            SHIFT: begin
                if (bus.ser_valid) begin
                    buf_d[cnt_q] = bus.ser_in;
                    if (cnt_q == 2'd3) begin
                        // Last bit goes straight to the output so the word is ready this edge
                        word_d  = {bus.ser_in, buf_q[2:0]};
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = 2'd0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            HOLD: begin
                if (bus.word_ready) begin
                    valid_d = 1'b0;
                    if (bus.start) begin
                        // Accepting a start wins over any bit that shows up now
                        state_d   = SHIFT;
                        cnt_d     = 2'd0;
                        overrun_d = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        if (bus.ser_valid) begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (bus.ser_valid) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately when rst drops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            buf_q     <= 4'd0;
            word_q    <= 4'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_four_bit_serial_loader.sv
// Bench for four_bit_serial_loader: a table of directed vectors, hand-written
// corner sequences, and a random run against a queue-based reference model.
module tb_four_bit_serial_loader;

    logic clk;
    logic rst;

    four_bit_serial_loader_if bus_if ();

    four_bit_serial_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       start;
        bit       ser_in;
        bit       ser_valid;
        bit       word_ready;
        bit [3:0] exp_word;
        bit       exp_valid;
        bit       exp_busy;
        bit       exp_overrun;
    } vec_t;

    vec_t vecs[$];

    int n_vectors;
    int n_miscompares;

    // Reference model: collected bits, whether a capture is running,
    // whether a finished word awaits acceptance, and the sticky overrun
    bit m_bits[$];
    bit m_capturing;
    bit m_pending;
    bit m_overrun;
    int m_word;

    task automatic model_reset();
        m_bits.delete();
        m_capturing = 1'b0;
        m_pending   = 1'b0;
        m_overrun   = 1'b0;
        m_word      = 0;
    endtask

    task automatic model_step(input bit st, input bit sin, input bit sv, input bit rdy);
        if (m_pending) begin
            if (rdy) begin
                m_pending = 1'b0;
                if (st) begin
                    m_capturing = 1'b1;
                    m_bits.delete();
                    m_overrun = 1'b0;
                end else if (sv) begin
                    m_overrun = 1'b1;
                end
            end else if (sv) begin
                m_overrun = 1'b1;
            end
        end else if (m_capturing) begin
            if (sv) begin
                m_bits.push_back(sin);
                if (m_bits.size() == 4) begin
                    m_word = 0;
                    foreach (m_bits[i]) m_word = m_word + (int'(m_bits[i]) << i);
                    m_pending   = 1'b1;
                    m_capturing = 1'b0;
                    m_bits.delete();
                end
            end
        end else if (st) begin
            m_capturing = 1'b1;
            m_bits.delete();
            m_overrun = 1'b0;
        end
    endtask

    task automatic check_output(input string name, input bit [3:0] ew, input bit ev,
                                input bit eb, input bit eo);
        bit bad;
        bad = 1'b0;
        n_vectors++;
        if (bus_if.word_out !== ew) begin
            $display("[TB] FAIL %s word_out: got %b, want %b", name, bus_if.word_out, ew);
            bad = 1'b1;
        end
        if (bus_if.word_valid !== ev) begin
            $display("[TB] FAIL %s word_valid: got %b, want %b", name, bus_if.word_valid, ev);
            bad = 1'b1;
        end
        if (bus_if.busy !== eb) begin
            $display("[TB] FAIL %s busy: got %b, want %b", name, bus_if.busy, eb);
            bad = 1'b1;
        end
        if (bus_if.overrun !== eo) begin
            $display("[TB] FAIL %s overrun: got %b, want %b", name, bus_if.overrun, eo);
            bad = 1'b1;
        end
        if (bad) n_miscompares++;
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the model
    // at the rising edge, and return at the next falling edge for sampling
    task automatic apply_stimulus(input bit st, input bit sin, input bit sv, input bit rdy);
        bus_if.start      = st;
        bus_if.ser_in     = sin;
        bus_if.ser_valid  = sv;
        bus_if.word_ready = rdy;
        @(posedge clk);
        model_step(st, sin, sv, rdy);
        @(negedge clk);
    endtask

    task automatic check_model(input string name);
        check_output(name, m_word[3:0], m_pending, m_capturing, m_overrun);
    endtask

    task automatic send_bit(input bit b, input string name);
        apply_stimulus(1'b0, b, 1'b1, 1'b0);
        check_model(name);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        bus_if.start      = 1'b0;
        bus_if.ser_in     = 1'b0;
        bus_if.ser_valid  = 1'b0;
        bus_if.word_ready = 1'b0;
        rst = 1'b0;
        model_reset();

        // Directed vectors: 1,0,1,1 with ready held high, then 0,1,1,0 with gaps
        vecs.push_back('{1,0,0,1, 4'b0000,0,1,0});
        vecs.push_back('{0,1,1,1, 4'b0000,0,1,0});
        vecs.push_back('{0,0,1,1, 4'b0000,0,1,0});
        vecs.push_back('{0,1,1,1, 4'b0000,0,1,0});
        vecs.push_back('{0,1,1,1, 4'b1101,1,0,0});
        vecs.push_back('{0,0,0,1, 4'b1101,0,0,0});
        vecs.push_back('{1,0,0,0, 4'b1101,0,1,0});
        vecs.push_back('{0,0,1,0, 4'b1101,0,1,0});
        vecs.push_back('{0,1,0,0, 4'b1101,0,1,0});
        vecs.push_back('{0,1,1,0, 4'b1101,0,1,0});
        vecs.push_back('{0,0,0,0, 4'b1101,0,1,0});
        vecs.push_back('{0,1,1,0, 4'b1101,0,1,0});
        vecs.push_back('{0,0,1,0, 4'b0110,1,0,0});
        vecs.push_back('{0,0,1,0, 4'b0110,1,0,1});
        vecs.push_back('{0,0,0,1, 4'b0110,0,0,1});

        repeat (2) @(negedge clk);
        check_output("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].start, vecs[i].ser_in, vecs[i].ser_valid, vecs[i].word_ready);
            check_output($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_valid,
                         vecs[i].exp_busy, vecs[i].exp_overrun);
        end

        // Word 1010 held while bits keep arriving, then drained; next start clears overrun
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_model("ovr_start");
        send_bit(1'b0, "ovr_b0");
        send_bit(1'b1, "ovr_b1");
        send_bit(1'b0, "ovr_b2");
        send_bit(1'b1, "ovr_b3");
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        check_output("ovr_hold", 4'b1010, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("ovr_drain", 4'b1010, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("ovr_clear", 4'b1010, 1'b0, 1'b1, 1'b0);

        // Fill a 0000 word, then ready+start together and bits 1,1,1,1
        for (int k = 0; k < 4; k++) send_bit(1'b0, "b2b_fill");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        check_output("b2b_restart", 4'b0000, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
            check_output("b2b_shift", 4'b0000, 1'b0, 1'b1, 1'b0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        check_output("b2b_word", 4'b1111, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_model("b2b_drain");

        // Asynchronous reset after two bits clears everything mid-cycle
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, "arst_b0");
        send_bit(1'b1, "arst_b1");
        #2 rst = 1'b0;
        #1 check_output("arst_clear", 4'b0000, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, "arst_n0");
        send_bit(1'b0, "arst_n1");
        send_bit(1'b1, "arst_n2");
        send_bit(1'b0, "arst_n3");
        check_output("arst_word", 4'b0100, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // start pulses during a capture must not restart it
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, "ign_b0");
        send_bit(1'b1, "ign_b1");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("ign_start", 4'b0100, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, "ign_b2");
        send_bit(1'b0, "ign_b3");
        check_output("ign_word", 4'b0011, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_model("ign_drain");

        // Random traffic compared against the reference model every cycle
        for (int k = 0; k < 600; k++) begin
            apply_stimulus(($urandom_range(3) == 0), 1'($urandom),
                           1'($urandom), ($urandom_range(2) == 0));
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
